// File: rtl/gato_pkg.sv
// Shared encodings for the tic-tac-toe board: cell codes, game status,
// control FSM states and the 3-bit RGB palette.
package gato_pkg;

  localparam logic [1:0] CELDA_VACIA = 2'b00;
  localparam logic [1:0] CELDA_X     = 2'b01;
  localparam logic [1:0] CELDA_O     = 2'b10;

  localparam logic [1:0] EST_JUGANDO = 2'b00;
  localparam logic [1:0] EST_GANA_X  = 2'b01;
  localparam logic [1:0] EST_GANA_O  = 2'b10;
  localparam logic [1:0] EST_EMPATE  = 2'b11;

  typedef enum logic [1:0] {
    JUEGO    = 2'd0,
    VERIFICA = 2'd1,
    FIN      = 2'd2
  } estadoFsm_t;

  localparam logic [2:0] NEGRO    = 3'b000;
  localparam logic [2:0] BLANCO   = 3'b111;
  localparam logic [2:0] ROJO     = 3'b100;
  localparam logic [2:0] AZUL     = 3'b001;
  localparam logic [2:0] VERDE    = 3'b010;
  localparam logic [2:0] AMARILLO = 3'b110;

endpackage

// File: rtl/gato_detector_linea.sv
// Combinational line detector: checks every row, column and both diagonals
// for the given player and reports win, full board and the winning cells.
import gato_pkg::*;

module gato_detector_linea #(
  parameter int N = 3
) (
  input  logic [N*N*2-1:0] tablero,
  input  logic [1:0]       jugador,
  output logic             gana,
  output logic             lleno,
  output logic [N*N-1:0]   mascara
);

  always_comb begin
    logic lineaOk;
    lineaOk = 1'b0;
    gana    = 1'b0;
    lleno   = 1'b1;
    mascara = '0;

    for (int i = 0; i < N*N; i++) begin
      if (tablero[2*i +: 2] == CELDA_VACIA) lleno = 1'b0;
    end

    for (int r = 0; r < N; r++) begin
      lineaOk = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (tablero[2*(r*N+c) +: 2] != jugador) lineaOk = 1'b0;
      end
      if (lineaOk) begin
        gana = 1'b1;
        for (int c = 0; c < N; c++) mascara[r*N+c] = 1'b1;
      end
    end

    for (int c = 0; c < N; c++) begin
      lineaOk = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (tablero[2*(r*N+c) +: 2] != jugador) lineaOk = 1'b0;
      end
      if (lineaOk) begin
        gana = 1'b1;
        for (int r = 0; r < N; r++) mascara[r*N+c] = 1'b1;
      end
    end

    lineaOk = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (tablero[2*(i*N+i) +: 2] != jugador) lineaOk = 1'b0;
    end
    if (lineaOk) begin
      gana = 1'b1;
      for (int i = 0; i < N; i++) mascara[i*N+i] = 1'b1;
    end

    lineaOk = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (tablero[2*(i*N+(N-1-i)) +: 2] != jugador) lineaOk = 1'b0;
    end
    if (lineaOk) begin
      gana = 1'b1;
      for (int i = 0; i < N; i++) mascara[i*N+(N-1-i)] = 1'b1;
    end
  end

endmodule

// File: rtl/gato_tablero_render.sv
// N x N tic-tac-toe board with move handshake, win/draw detection and a
// registered VGA pixel colour stage driven by the sync generator's coordinates.
import gato_pkg::*;

module gato_tablero_render #(
  parameter int N         = 3,
  parameter int ORIGEN_X  = 160,
  parameter int ORIGEN_Y  = 120,
  parameter int CELDA_W   = 80,
  parameter int CELDA_H   = 60,
  parameter int GROSOR    = 4,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        video_mostrar,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [4:0]  cursor,
  input  logic        jugada_valid,
  output logic        jugada_ready,
  output logic        jugada_err,
  input  logic        reiniciar,
  output logic        turno,
  output logic [1:0]  estado,
  output logic [2:0]  salida_rgb
);

  localparam int CELDAS = N * N;
  localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  estadoFsm_t          fsm, fsmNext;
  logic [CELDAS*2-1:0] tablero;
  logic [CELDAS-1:0]   mascaraGan, mascaraDet;
  logic                rstDone, gana, lleno;
  logic [1:0]          jugador, celdaCursor;
  logic                movOk, fire;
  logic [CNT_W-1:0]    blinkCnt;
  logic                fase;

  assign jugador      = turno ? CELDA_O : CELDA_X;
  assign jugada_ready = rstDone && (fsm != VERIFICA);
  assign fire         = jugada_valid && jugada_ready && !reiniciar;

  always_comb begin
    celdaCursor = CELDA_VACIA;
    for (int i = 0; i < CELDAS; i++) begin
      if (cursor == 5'(i)) celdaCursor = tablero[2*i +: 2];
    end
    movOk = (cursor < 5'(CELDAS)) && (celdaCursor == CELDA_VACIA);
  end

  gato_detector_linea #(.N(N)) uDetector (
    .tablero (tablero),
    .jugador (jugador),
    .gana    (gana),
    .lleno   (lleno),
    .mascara (mascaraDet)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= JUEGO;
    else        fsm <= fsmNext;
  end

  always_comb begin
    fsmNext = fsm;
    case (fsm)
      JUEGO:    if (fire && movOk) fsmNext = VERIFICA;
      VERIFICA: fsmNext = (gana || lleno) ? FIN : JUEGO;
      FIN:      fsmNext = FIN;
      default:  fsmNext = JUEGO;
    endcase
    if (reiniciar) fsmNext = JUEGO;
  end

  // Board, turn and result; the board written at the accept edge is the one
  // the detector sees during VERIFICA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tablero    <= '0;
      mascaraGan <= '0;
      turno      <= 1'b0;
      estado     <= EST_JUGANDO;
      jugada_err <= 1'b0;
      rstDone    <= 1'b0;
    end else begin
      rstDone    <= 1'b1;
      jugada_err <= 1'b0;
      if (reiniciar) begin
        tablero    <= '0;
        mascaraGan <= '0;
        turno      <= 1'b0;
        estado     <= EST_JUGANDO;
      end else begin
        case (fsm)
          JUEGO: begin
            if (fire) begin
              if (movOk) begin
                for (int i = 0; i < CELDAS; i++) begin
                  if (cursor == 5'(i)) tablero[2*i +: 2] <= jugador;
                end
              end else begin
                jugada_err <= 1'b1;
              end
            end
          end
          VERIFICA: begin
            if (gana) begin
              estado     <= turno ? EST_GANA_O : EST_GANA_X;
              mascaraGan <= mascaraDet;
            end else if (lleno) begin
              estado <= EST_EMPATE;
            end else begin
              turno <= ~turno;
            end
          end
          FIN:     if (fire) jugada_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt <= '0;
      fase     <= 1'b0;
    end else if (blinkCnt == CNT_W'(BLINK_DIV - 1)) begin
      blinkCnt <= '0;
      fase     <= ~fase;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
    end
  end

  logic [10:0] baseX, baseY, offX, offY;
  logic [2:0]  col, fila;
  logic [4:0]  idxPix;
  logic        dentro, lineaPix, ganaPix;
  logic [1:0]  celdaPix;
  logic [2:0]  rgbNext;

  // Cell lookup by boundary comparison; baseX/baseY track the left/top edge
  // of the cell the pixel falls in.
  always_comb begin
    col   = '0;
    fila  = '0;
    baseX = 11'(ORIGEN_X);
    baseY = 11'(ORIGEN_Y);
    for (int k = 1; k < N; k++) begin
      if (pixel_x >= 11'(ORIGEN_X + k*CELDA_W)) begin
        col   = col + 3'd1;
        baseX = 11'(ORIGEN_X + k*CELDA_W);
      end
      if (pixel_y >= 11'(ORIGEN_Y + k*CELDA_H)) begin
        fila  = fila + 3'd1;
        baseY = 11'(ORIGEN_Y + k*CELDA_H);
      end
    end
    offX   = pixel_x - baseX;
    offY   = pixel_y - baseY;
    dentro = (pixel_x >= 11'(ORIGEN_X)) && (pixel_x <= 11'(ORIGEN_X + N*CELDA_W - 1)) &&
             (pixel_y >= 11'(ORIGEN_Y)) && (pixel_y <= 11'(ORIGEN_Y + N*CELDA_H - 1));
    lineaPix = dentro &&
               (((col != 3'(N-1)) && (offX >= 11'(CELDA_W - GROSOR))) ||
                ((fila != 3'(N-1)) && (offY >= 11'(CELDA_H - GROSOR))));
    idxPix   = 5'(fila) * 5'(N) + 5'(col);
    celdaPix = CELDA_VACIA;
    ganaPix  = 1'b0;
    for (int i = 0; i < CELDAS; i++) begin
      if (idxPix == 5'(i)) begin
        celdaPix = tablero[2*i +: 2];
        ganaPix  = mascaraGan[i];
      end
    end
  end

  always_comb begin
    rgbNext = BLANCO;
    if (!video_mostrar)                                          rgbNext = NEGRO;
    else if (lineaPix)                                           rgbNext = NEGRO;
    else if (dentro && fsm == FIN && ganaPix)                    rgbNext = VERDE;
    else if (dentro && fase && fsm != FIN && idxPix == cursor)   rgbNext = AMARILLO;
    else if (dentro && celdaPix == CELDA_X)                      rgbNext = ROJO;
    else if (dentro && celdaPix == CELDA_O)                      rgbNext = AZUL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) salida_rgb <= NEGRO;
    else        salida_rgb <= rgbNext;
  end

endmodule

// File: tb/tb_gato_tablero_render.sv
// Directed bench for the tic-tac-toe board/renderer with a short blink period.
module tb_gato_tablero_render;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_mostrar;
  logic [10:0] pixel_x, pixel_y;
  logic [4:0]  cursor;
  logic        jugada_valid, jugada_ready, jugada_err, reiniciar, turno;
  logic [1:0]  estado;
  logic [2:0]  salida_rgb;
  int          checks = 0;
  int          errors = 0;
  logic        errSeen;

  gato_tablero_render #(.N(3), .BLINK_DIV(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .video_mostrar (video_mostrar),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .cursor        (cursor),
    .jugada_valid  (jugada_valid),
    .jugada_ready  (jugada_ready),
    .jugada_err    (jugada_err),
    .reiniciar     (reiniciar),
    .turno         (turno),
    .estado        (estado),
    .salida_rgb    (salida_rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [2:0] exp, input string tag);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    step();
    chk(tag, {1'b0, salida_rgb}, {1'b0, exp});
  endtask

  task automatic jugar(input int idx, output logic e);
    cursor       = 5'(idx);
    jugada_valid = 1'b1;
    step();
    jugada_valid = 1'b0;
    e            = jugada_err;
    step();
    cursor       = 5'd8;
  endtask

  task automatic limpiar();
    reiniciar = 1'b1;
    step();
    reiniciar = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; video_mostrar = 1'b1; pixel_x = 11'd170; pixel_y = 11'd130;
    cursor = 5'd8; jugada_valid = 1'b0; reiniciar = 1'b0;
    #2;
    chk("rst_ready", {3'b0, jugada_ready}, 4'h0);
    chk("rst_err",   {3'b0, jugada_err},   4'h0);
    chk("rst_estado", {2'b0, estado},      4'h0);
    chk("rst_turno", {3'b0, turno},        4'h0);
    chk("rst_rgb",   {1'b0, salida_rgb},   4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ready_after_rst", {3'b0, jugada_ready}, 4'h1);

    // Renderer on an empty board
    pix(170, 130, 3'b111, "empty_cell0");
    pix(237, 150, 3'b000, "vline");
    pix(170, 178, 3'b000, "hline");
    pix(398, 130, 3'b111, "no_outer_border");
    pix(400, 130, 3'b111, "outside_right");
    pix(100, 100, 3'b111, "outside_ul");
    video_mostrar = 1'b0;
    pix(170, 130, 3'b000, "blanking");
    video_mostrar = 1'b1;

    // X wins on the top row
    jugar(0, errSeen);
    chk("x0_err", {3'b0, errSeen}, 4'h0);
    chk("turno_after_x", {3'b0, turno}, 4'h1);
    jugar(4, errSeen);
    jugar(1, errSeen);
    jugar(8, errSeen);
    cursor = 5'd2; jugada_valid = 1'b1;
    step();
    jugada_valid = 1'b0;
    chk("verifica_ready", {3'b0, jugada_ready}, 4'h0);
    chk("estado_before", {2'b0, estado}, 4'h0);
    step();
    chk("estado_gana_x", {2'b0, estado}, 4'h1);
    chk("fin_ready", {3'b0, jugada_ready}, 4'h1);
    pix(170, 130, 3'b010, "win_cell0");
    pix(250, 130, 3'b010, "win_cell1");
    pix(330, 130, 3'b010, "win_cell2");
    pix(250, 190, 3'b001, "o_cell4");
    pix(170, 190, 3'b111, "empty_cell3");
    jugar(5, errSeen);
    chk("fin_err", {3'b0, errSeen}, 4'h1);
    chk("fin_err_clear", {3'b0, jugada_err}, 4'h0);
    chk("fin_estado_hold", {2'b0, estado}, 4'h1);
    pix(330, 190, 3'b111, "fin_cell5_unchanged");

    limpiar();
    chk("clr_estado", {2'b0, estado}, 4'h0);
    chk("clr_turno", {3'b0, turno}, 4'h0);
    pix(170, 130, 3'b111, "clr_cell0");

    // Rejected moves
    jugar(4, errSeen);
    chk("x4_ok", {3'b0, errSeen}, 4'h0);
    jugar(4, errSeen);
    chk("occupied_err", {3'b0, errSeen}, 4'h1);
    chk("occupied_turno", {3'b0, turno}, 4'h1);
    jugar(9, errSeen);
    chk("range_err", {3'b0, errSeen}, 4'h1);
    chk("range_turno", {3'b0, turno}, 4'h1);
    pix(250, 190, 3'b100, "x_cell4_kept");
    limpiar();

    // Draw
    jugar(0, errSeen); jugar(1, errSeen); jugar(2, errSeen);
    jugar(4, errSeen); jugar(3, errSeen); jugar(5, errSeen);
    jugar(7, errSeen); jugar(6, errSeen);
    chk("pre_draw_estado", {2'b0, estado}, 4'h0);
    jugar(8, errSeen);
    chk("draw_estado", {2'b0, estado}, 4'h3);
    limpiar();

    // Clear wins over a simultaneous move
    cursor = 5'd0; jugada_valid = 1'b1; reiniciar = 1'b1;
    step();
    jugada_valid = 1'b0; reiniciar = 1'b0; cursor = 5'd8;
    chk("clr_mv_err", {3'b0, jugada_err}, 4'h0);
    chk("clr_mv_turno", {3'b0, turno}, 4'h0);
    pix(170, 130, 3'b111, "clr_mv_cell0");
    jugar(0, errSeen);
    chk("clr_mv_cell0_free", {3'b0, errSeen}, 4'h0);

    // Asynchronous reset in the middle of VERIFICA
    cursor = 5'd1; jugada_valid = 1'b1;
    step();
    jugada_valid = 1'b0;
    chk("mid_ready", {3'b0, jugada_ready}, 4'h0);
    chk("mid_turno", {3'b0, turno}, 4'h1);
    chk("mid_rgb", {1'b0, salida_rgb}, 4'h4);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {3'b0, jugada_ready}, 4'h0);
    chk("arst_turno", {3'b0, turno}, 4'h0);
    chk("arst_estado", {2'b0, estado}, 4'h0);
    chk("arst_err", {3'b0, jugada_err}, 4'h0);
    chk("arst_rgb", {1'b0, salida_rgb}, 4'h0);

    // Cursor blink on cell 4 after a fresh reset
    cursor = 5'd4; pixel_x = 11'd250; pixel_y = 11'd190;
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("blink_%0d", k), {1'b0, salida_rgb},
          (((k - 1) / 4) % 2 == 1) ? 4'h6 : 4'h7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
